// File: rtl/jzjpcc_pkg.sv
// jzjpcc_pkg: shared types and constants for the jzjpcc pipeline.
//   rdSource_t : where the rd value comes from (ALU, MEMORY, PC_PLUS_4)
//   memState_t : memory-stage bus FSM states
//   LB..LHU    : funct3 load width/sign encodings
package jzjpcc_pkg;
  typedef enum logic [1:0] {ALU = 2'd0, MEMORY = 2'd1, PC_PLUS_4 = 2'd2} rdSource_t;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} memState_t;
  localparam logic [2:0] LB = 3'd0;
  localparam logic [2:0] LH = 3'd1;
  localparam logic [2:0] LW = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
endpackage

// File: rtl/jzjpcc_load_extractor.sv
// jzjpcc_load_extractor: selects and extends load data from a bus word.
//   readWord : word returned by the data bus
//   offset   : byte offset within the word (address[1:0])
//   funct3   : load width/sign; anything that is not a byte/halfword load reads the full word
//   rdValue  : extended value destined for rd
module jzjpcc_load_extractor
  import jzjpcc_pkg::*;
(
  input  logic [31:0] readWord,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] rdValue
);
  logic [7:0] byteLane;
  logic [15:0] halfLane;
  always_comb begin
    byteLane = readWord[{offset, 3'b000} +: 8];
    halfLane = offset[1] ? readWord[31:16] : readWord[15:0];
    rdValue = funct3 == LB  ? {{24{byteLane[7]}}, byteLane} :
              funct3 == LBU ? {24'd0, byteLane} :
              funct3 == LH  ? {{16{halfLane[15]}}, halfLane} :
              funct3 == LHU ? {16'd0, halfLane} : readWord;
  end
endmodule

// File: rtl/jzjpcc_memory.sv
// jzjpcc_memory: memory stage; runs loads/stores over a request/ready bus and registers rd results.
//   clock, reset (async, active-low)
//   execute side : inValid, aluResult, rdAddr, rdSource, rdWriteEnable, memoryWriteEnable,
//                  memDataToWrite, memByteMask, funct3 -> memoryStall
//   data bus     : dataAddress, dataWriteData, dataByteMask, dataWriteEnable, dataRequest <- dataReady, dataReadData
//   writeback    : wbRdAddr, wbRdWriteEnable, wbRdData, misalignedFault, busFault
module jzjpcc_memory
  import jzjpcc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        inValid,
  input  logic [31:0] aluResult,
  input  logic [4:0]  rdAddr,
  input  logic [1:0]  rdSource,
  input  logic        rdWriteEnable,
  input  logic        memoryWriteEnable,
  input  logic [31:0] memDataToWrite,
  input  logic [3:0]  memByteMask,
  input  logic [2:0]  funct3,
  output logic        memoryStall,
  output logic [29:0] dataAddress,
  output logic [31:0] dataWriteData,
  output logic [3:0]  dataByteMask,
  output logic        dataWriteEnable,
  output logic        dataRequest,
  input  logic        dataReady,
  input  logic [31:0] dataReadData,
  output logic [4:0]  wbRdAddr,
  output logic        wbRdWriteEnable,
  output logic [31:0] wbRdData,
  output logic        misalignedFault,
  output logic        busFault
);
  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);
  memState_t state, nextState;
  logic [15:0] waitCount;
  logic memOp, isLoad, isByte, isHalf, misaligned, access, timedOut, complete;
  logic [31:0] loadValue;
  jzjpcc_load_extractor extractor (
    .readWord(dataReadData),
    .offset(aluResult[1:0]),
    .funct3(funct3),
    .rdValue(loadValue)
  );
  always_comb begin
    memOp = inValid & (memoryWriteEnable | rdSource == MEMORY);
    isLoad = memOp & ~memoryWriteEnable;
    isByte = funct3 == LB | funct3 == LBU;
    isHalf = funct3 == LH | funct3 == LHU;
    misaligned = isLoad & (isHalf ? aluResult[0] : ~isByte & |aluResult[1:0]);
    // in WAIT the upstream inputs are frozen, so the access stays live without re-decoding
    access = state == WAIT | (memOp & ~misaligned);
    // ready on the final allowed cycle still wins over the abort
    timedOut = state == WAIT & waitCount == TIMEOUT & ~dataReady;
    complete = access & dataReady;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nextState;
  always_comb nextState = access & ~dataReady & ~timedOut ? WAIT : IDLE;
  always_comb begin
    // gating with reset drops the request the instant reset asserts, even mid-access
    dataRequest = reset & access & ~timedOut;
    memoryStall = reset & access & ~dataReady & ~timedOut;
    dataWriteEnable = dataRequest & memoryWriteEnable;
    dataAddress = aluResult[31:2];
    dataWriteData = memDataToWrite;
    dataByteMask = memByteMask;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      waitCount <= '0;
      wbRdAddr <= '0;
      wbRdData <= '0;
      wbRdWriteEnable <= 1'b0;
      misalignedFault <= 1'b0;
      busFault <= 1'b0;
    end else begin
      waitCount <= state == WAIT && nextState == WAIT ? waitCount + 16'd1 : '0;
      wbRdAddr <= rdAddr;
      wbRdData <= isLoad ? loadValue : aluResult;
      // loads write back only on their completing cycle; stalled cycles become bubbles
      wbRdWriteEnable <= inValid & rdWriteEnable & ~memoryWriteEnable & (~isLoad | complete);
      misalignedFault <= misaligned & state == IDLE;
      busFault <= timedOut;
    end
endmodule

// File: tb/tb_jzjpcc_memory.sv
// tb_jzjpcc_memory: scoreboard bench for jzjpcc_memory with a behavioural bus/writeback model.
module tb_jzjpcc_memory;
  import jzjpcc_pkg::*;
  localparam int T = 4;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic inValid = 1'b0;
  logic [31:0] aluResult = '0;
  logic [4:0] rdAddr = '0;
  logic [1:0] rdSource = '0;
  logic rdWriteEnable = 1'b0;
  logic memoryWriteEnable = 1'b0;
  logic [31:0] memDataToWrite = '0;
  logic [3:0] memByteMask = '0;
  logic [2:0] funct3 = '0;
  logic dataReady = 1'b0;
  logic [31:0] dataReadData = '0;
  logic memoryStall, dataWriteEnable, dataRequest, wbRdWriteEnable, misalignedFault, busFault;
  logic [29:0] dataAddress;
  logic [31:0] dataWriteData, wbRdData;
  logic [3:0] dataByteMask;
  logic [4:0] wbRdAddr;
  typedef struct {
    logic we;
    logic [4:0] addr;
    logic [31:0] data;
    logic mis;
    logic bus;
  } exp_t;
  exp_t expq[$];
  int total = 0;
  int bad = 0;
  jzjpcc_memory #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .aluResult(aluResult), .rdAddr(rdAddr),
    .rdSource(rdSource), .rdWriteEnable(rdWriteEnable), .memoryWriteEnable(memoryWriteEnable),
    .memDataToWrite(memDataToWrite), .memByteMask(memByteMask), .funct3(funct3),
    .memoryStall(memoryStall), .dataAddress(dataAddress), .dataWriteData(dataWriteData),
    .dataByteMask(dataByteMask), .dataWriteEnable(dataWriteEnable), .dataRequest(dataRequest),
    .dataReady(dataReady), .dataReadData(dataReadData), .wbRdAddr(wbRdAddr),
    .wbRdWriteEnable(wbRdWriteEnable), .wbRdData(wbRdData), .misalignedFault(misalignedFault),
    .busFault(busFault)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask
  function automatic int accessSize(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction
  function automatic logic [31:0] loadModel(input logic [31:0] word, input logic [1:0] off, input logic [2:0] f3);
    logic [31:0] s;
    s = word >> (8 * int'(off));
    case (accessSize(f3))
      1: return f3 == 3'd0 ? 32'($signed(s[7:0])) : 32'(s[7:0]);
      2: return f3 == 3'd1 ? 32'($signed(s[15:0])) : 32'(s[15:0]);
      default: return word;
    endcase
  endfunction
  // w = cycle index (0 = issue cycle) on which the bus raises ready; w > T+1 means never
  task automatic runOp(input logic v, input logic [1:0] src, input logic rwe, input logic mwe,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input logic [4:0] rd, input logic [31:0] rword, input int w);
    logic memOp, isLoad, mis, acc, rdy, expReq, expStall, done;
    exp_t e;
    int k;
    @(negedge clock);
    inValid = v; rdSource = src; rdWriteEnable = rwe; memoryWriteEnable = mwe; funct3 = f3;
    aluResult = addr; memDataToWrite = wdata; memByteMask = mask; rdAddr = rd; dataReadData = rword;
    memOp = v && (mwe || src == 2'd1);
    isLoad = memOp && !mwe;
    mis = isLoad && (int'(addr[1:0]) % accessSize(f3) != 0);
    acc = memOp && !mis;
    e.we = 1'b0; e.addr = rd; e.data = 32'd0; e.mis = 1'b0; e.bus = 1'b0;
    if (!memOp) begin
      if (v && rwe) begin e.we = 1'b1; e.data = addr; expq.push_back(e); end
    end else if (mis) begin
      e.mis = 1'b1; expq.push_back(e);
    end else if (w > T + 1) begin
      e.bus = 1'b1; expq.push_back(e);
    end else if (isLoad && rwe) begin
      e.we = 1'b1; e.data = loadModel(rword, addr[1:0], f3); expq.push_back(e);
    end
    k = 0;
    dataReady = acc ? (k == w) : 1'($urandom_range(0, 1));
    forever begin
      #1;
      rdy = acc && k == w;
      expReq = acc && (rdy || k <= T);
      expStall = acc && !rdy && k <= T;
      check("dataRequest", dataRequest, expReq);
      check("memoryStall", memoryStall, expStall);
      check("dataWriteEnable", dataWriteEnable, expReq && mwe);
      if (expReq) begin
        check("dataAddress", dataAddress, addr >> 2);
        check("dataWriteData", dataWriteData, wdata);
        check("dataByteMask", dataByteMask, mask);
      end
      done = !acc || rdy || k == T + 1;
      @(posedge clock);
      if (done) break;
      @(negedge clock);
      k++;
      dataReady = (k == w);
    end
  endtask
  always @(negedge clock)
    if (reset && (wbRdWriteEnable || misalignedFault || busFault)) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected writeback: we=%b rd=%0d data=%h mis=%b bus=%b at %0t",
                 wbRdWriteEnable, wbRdAddr, wbRdData, misalignedFault, busFault, $time);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("wbRdWriteEnable", wbRdWriteEnable, e.we);
        check("misalignedFault", misalignedFault, e.mis);
        check("busFault", busFault, e.bus);
        if (e.we) begin
          check("wbRdAddr", wbRdAddr, e.addr);
          check("wbRdData", wbRdData, e.data);
        end
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("reset dataRequest", dataRequest, 0);
    check("reset memoryStall", memoryStall, 0);
    check("reset wbRdWriteEnable", wbRdWriteEnable, 0);
    check("reset wbRdAddr", wbRdAddr, 0);
    check("reset wbRdData", wbRdData, 0);
    check("reset misalignedFault", misalignedFault, 0);
    check("reset busFault", busFault, 0);
    @(negedge clock);
    reset = 1'b1;
    runOp(1, 2'd0, 1, 0, 3'd0, 32'h0000_1234, 0, 0, 5, 0, 99);
    runOp(1, 2'd1, 1, 0, LB, 32'h103, 0, 0, 7, 32'h80AA_BBCC, 0);
    runOp(1, 2'd1, 1, 0, LBU, 32'h103, 0, 0, 8, 32'h80AA_BBCC, 0);
    runOp(1, 2'd0, 1, 1, LW, 32'h200, 32'hDEAD_BEEF, 4'hF, 9, 0, 3);
    runOp(1, 2'd1, 1, 0, LH, 32'h201, 0, 0, 3, 32'h1234_5678, 0);
    runOp(1, 2'd1, 1, 0, LW, 32'h300, 0, 0, 4, 32'h1111_2222, 99);
    runOp(1, 2'd1, 1, 0, LW, 32'h304, 0, 0, 6, 32'hCAFE_F00D, 0);
    runOp(1, 2'd1, 1, 0, LHU, 32'h302, 0, 0, 10, 32'h8765_4321, T + 1);
    runOp(1, 2'd2, 1, 0, 3'd0, 32'h0000_0ABC, 0, 0, 12, 0, 0);
    repeat (150) begin
      int kind;
      logic v, rwe, mwe;
      logic [1:0] src;
      int w;
      kind = $urandom_range(0, 9);
      v = 1'b1; rwe = 1'($urandom_range(0, 1)); mwe = 1'b0; src = 2'd1;
      if (kind <= 2) src = $urandom_range(0, 1) ? 2'd0 : 2'd2;
      else if (kind <= 4) begin mwe = 1'b1; src = 2'($urandom_range(0, 2)); end
      else if (kind == 5) begin v = 1'b0; src = 2'($urandom_range(0, 2)); mwe = 1'($urandom_range(0, 1)); end
      w = ($urandom_range(0, 7) == 0) ? $urandom_range(T + 1, T + 5) : $urandom_range(0, 3);
      runOp(v, src, rwe, mwe, 3'($urandom_range(0, 7)), $urandom, $urandom, 4'($urandom_range(0, 15)),
            5'($urandom_range(0, 31)), $urandom, w);
    end
    @(negedge clock);
    inValid = 1'b1; rdSource = 2'd1; rdWriteEnable = 1'b1; memoryWriteEnable = 1'b0; funct3 = LW;
    aluResult = 32'h400; rdAddr = 5'd11; dataReady = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    check("pre-reset dataRequest", dataRequest, 1);
    check("pre-reset memoryStall", memoryStall, 1);
    #1 reset = 1'b0;
    #1;
    check("mid-wait reset dataRequest", dataRequest, 0);
    check("mid-wait reset memoryStall", memoryStall, 0);
    inValid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1 check("abandoned load wbRdWriteEnable", wbRdWriteEnable, 0);
    runOp(1, 2'd1, 1, 0, LH, 32'h502, 0, 0, 13, 32'h9ABC_0000, 2);
    runOp(0, 2'd0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    check("scoreboard drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
